// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared constants and FSM encoding for the instruction fetch stage
package if_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int          PC_INC           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - fetch address register with reset, increment and word-aligned redirect load
module fetch_pc_reg
  import if_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_inc,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_load_pc,
  output logic [DATA_WIDTH-1:0] o_fetch_pc
);

  logic [DATA_WIDTH-1:0] r_fetch_pc;

  // Load wins over increment so a redirect always overrides a handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (i_load) begin
      r_fetch_pc <= i_load_pc & ~DATA_WIDTH'(3);
    end else if (i_inc) begin
      r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(PC_INC);
    end
  end

  assign o_fetch_pc = r_fetch_pc;

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - single-outstanding instruction fetch FSM presenting pc/pcn/instr to decode
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pcn,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  valid
);

  localparam logic [DATA_WIDTH-1:0] NOP_W = DATA_WIDTH'(NOP_INSTR);
  localparam logic [DATA_WIDTH-1:0] INC_W = DATA_WIDTH'(PC_INC);

  fetch_state_t          r_state;
  logic                  r_drop;
  logic                  r_imem_req;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_pcn;
  logic [DATA_WIDTH-1:0] r_instr;
  logic                  r_valid;

  logic [DATA_WIDTH-1:0] w_fetch_pc;
  logic                  w_pc_inc;

  assign w_pc_inc = (r_state == ST_HOLD) && !stall && !redirect;

  fetch_pc_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .RESET_PC  (RESET_PC)
  ) u_fetch_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .i_inc     (w_pc_inc),
    .i_load    (redirect),
    .i_load_pc (redirect_pc),
    .o_fetch_pc(w_fetch_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_drop     <= 1'b0;
      r_imem_req <= 1'b0;
      r_pc       <= '0;
      r_pcn      <= '0;
      r_instr    <= NOP_W;
      r_valid    <= 1'b0;
    end else begin
      if (redirect) begin
        r_valid <= 1'b0;
        r_instr <= NOP_W;
      end
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_REQ;
          r_imem_req <= 1'b1;
        end
        ST_REQ: begin
          // A granted request that gets redirected still owes us a response.
          if (imem_gnt) begin
            r_state    <= ST_WAIT;
            r_imem_req <= 1'b0;
            r_drop     <= redirect;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            r_drop <= 1'b0;
            if (redirect || r_drop) begin
              r_state    <= ST_REQ;
              r_imem_req <= 1'b1;
            end else begin
              r_state <= ST_HOLD;
              r_pc    <= w_fetch_pc;
              r_pcn   <= w_fetch_pc + INC_W;
              r_instr <= imem_rdata;
              r_valid <= 1'b1;
            end
          end else if (redirect) begin
            r_drop <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect || !stall) begin
            r_state    <= ST_REQ;
            r_imem_req <= 1'b1;
            r_valid    <= 1'b0;
            r_instr    <= NOP_W;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = w_fetch_pc;
  assign pc        = r_pc;
  assign pcn       = r_pcn;
  assign instr     = r_instr;
  assign valid     = r_valid;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - scoreboard bench for if_fetch: directed fetch, stall, redirect, wrap and reset cases
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcn;
    logic [31:0] instr;
  } fetch_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc;
  logic [31:0] pcn;
  logic [31:0] instr;
  logic        valid;

  int total = 0;
  int bad = 0;
  logic prev_valid = 1'b0;
  logic [31:0] exp_addr[$];
  fetch_exp_t  exp_fetch[$];

  if_fetch #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .pcn        (pcn),
    .instr      (instr),
    .valid      (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (imem_req !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL req_timeout: imem_req=%b expected 1 within 20 cycles", imem_req);
    end
  endtask

  task automatic grant();
    wait_req();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] data);
    grant();
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
  endtask

  // Monitor: every accepted request and every newly presented instruction is scored.
  always @(negedge clk) begin
    fetch_exp_t e;
    if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
      if (exp_addr.size() == 0) chk("unexpected_req", imem_addr, 32'hxxxx_xxxx);
      else chk("req_addr", imem_addr, exp_addr.pop_front());
    end
    if (valid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_fetch.size() == 0) begin
        chk("unexpected_valid", {31'b0, valid}, 32'h0);
      end else begin
        e = exp_fetch.pop_front();
        chk("out_pc", pc, e.pc);
        chk("out_pcn", pcn, e.pcn);
        chk("out_instr", instr, e.instr);
      end
    end else if (valid === 1'b0) begin
      chk("nop_when_invalid", instr, NOP);
    end
    prev_valid <= valid;
  end

  initial begin
    step();
    step();
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pcn", pcn, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    rst = 1'b0;
    step();
    chk("idle_then_req", {31'b0, imem_req}, 32'h1);

    // Basic fetch then a back-to-back second fetch
    exp_addr.push_back(32'h0);
    exp_fetch.push_back('{32'h0, 32'h4, 32'h0050_0093});
    do_fetch(32'h0050_0093);
    exp_addr.push_back(32'h4);
    exp_fetch.push_back('{32'h4, 32'h8, 32'h0010_0113});
    do_fetch(32'h0010_0113);

    // Stall holds everything for three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 32'h4);
      chk("stall_instr", instr, 32'h0010_0113);
      chk("stall_valid", {31'b0, valid}, 32'h1);
      chk("stall_req", {31'b0, imem_req}, 32'h0);
    end
    stall = 1'b0;
    exp_addr.push_back(32'h8);
    grant();

    // Redirect in WAIT: response dropped, refetch at aligned target
    redirect = 1'b1;
    redirect_pc = 32'h0000_0102;
    step();
    redirect = 1'b0;
    step();
    chk("drop_wait_req", {31'b0, imem_req}, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("drop_then_req", {31'b0, imem_req}, 32'h1);
    chk("drop_addr", imem_addr, 32'h0000_0100);

    // Redirect coincident with rvalid
    exp_addr.push_back(32'h0000_0100);
    grant();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    step();
    redirect = 1'b0;
    imem_rvalid = 1'b0;
    chk("coinc_req", {31'b0, imem_req}, 32'h1);
    chk("coinc_addr", imem_addr, 32'h0000_0200);

    // Redirect in REQ without grant, then wrap at top of address space
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    chk("wrap_target", imem_addr, 32'hFFFF_FFFC);
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_fetch.push_back('{32'hFFFF_FFFC, 32'h0, 32'h00A0_0513});
    do_fetch(32'h00A0_0513);
    step();
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Reset mid-WAIT, stale rvalid afterwards is ignored
    exp_addr.push_back(32'h0);
    grant();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_req", {31'b0, imem_req}, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD1_BAD1;
    step();
    imem_rvalid = 1'b0;
    chk("post_rst_addr", imem_addr, 32'h0);
    exp_addr.push_back(32'h0);
    exp_fetch.push_back('{32'h0, 32'h4, 32'h1234_5678});
    stall = 1'b1;
    do_fetch(32'h1234_5678);
    step();
    step();

    chk("addr_queue_empty", exp_addr.size(), 32'h0);
    chk("fetch_queue_empty", exp_fetch.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  high means the decode pipeline register does not capture this cycle.
REQ-006 SHALL have port redirect  input  1  branch/jump/flush taken.
REQ-007 SHALL have port redirect_pc  input  DATA_WIDTH  new fetch target.
REQ-008 SHALL have port imem_req  output  1  instruction memory request.
REQ-009 SHALL have port imem_addr  output  DATA_WIDTH  request address.
REQ-010 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-011 SHALL have port imem_rvalid  input  1  read data valid.
REQ-012 SHALL have port imem_rdata  input  DATA_WIDTH  instruction word.
REQ-013 SHALL have port pc  output  DATA_WIDTH  address of presented instruction.
REQ-014 SHALL have port pcn  output  DATA_WIDTH  pc+4.
REQ-015 SHALL have port instr  output  DATA_WIDTH  presented instruction.
REQ-016 SHALL have port valid  output  1  pc/pcn/instr meaningful.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, HOLD; one outstanding request max.
REQ-018 IDLE SHALL last exactly one cycle after reset, then go to REQ.
REQ-019 REQ SHALL drive imem_req=1, imem_addr=fetch_pc; on imem_gnt -> WAIT; imem_req=0 in all other states.
REQ-020 WAIT on imem_rvalid (no drop pending) SHALL register pc=fetch_pc, pcn=fetch_pc+4, instr=imem_rdata, valid=1, -> HOLD; outputs visible the cycle after rvalid.
REQ-021 HOLD with stall=0 SHALL count as handoff: next cycle fetch_pc=fetch_pc+4, valid=0, instr=NOP, state REQ; with stall=1, all outputs SHALL hold unchanged.
REQ-022 pcn and fetch_pc+4 SHALL wrap modulo 2^DATA_WIDTH (32'hFFFF_FFFC+4 = 0).
REQ-023 redirect=1 in any non-reset state SHALL set fetch_pc=redirect_pc with bits[1:0] forced to 0, valid=0, instr=NOP next cycle; redirect has priority over handoff and rvalid capture.
REQ-024 redirect in WAIT without rvalid, or in REQ with imem_gnt same cycle, SHALL set drop flag, go to WAIT; the next rvalid SHALL be discarded, then -> REQ with the redirected fetch_pc.
REQ-025 redirect in WAIT coincident with imem_rvalid SHALL discard the data and go to REQ (no drop flag).
REQ-026 redirect in REQ without gnt, or in HOLD, SHALL go to REQ.
REQ-027 imem_rvalid in IDLE, REQ or HOLD SHALL be ignored.
REQ-028 When valid=0, instr SHALL be NOP (32'h0000_0013); pc/pcn SHALL retain their last values.

Reset
REQ-029 rst SHALL take priority over all inputs, including mid-WAIT; the outstanding response is forgotten.
REQ-030 Reset values SHALL be: state IDLE, fetch_pc=RESET_PC, pc=0, pcn=0, instr=NOP, valid=0, imem_req=0, imem_addr=RESET_PC, drop=0.

Structure
REQ-031 Shared package/header SHALL hold RESET_PC default, NOP encoding, PC increment constant 4, FSM state encodings.
REQ-032 Sub-module fetch_pc_reg SHALL hold fetch_pc with reset, increment, and redirect load; remaining logic stays in if_fetch.

Verification
REQ-033 Reset, gnt same cycle as req, rvalid one cycle later with 32'h00500093, stall=0 -> pc=0, pcn=4, instr=32'h00500093, valid=1; next imem_addr=4.
REQ-034 Hold state with stall=1 for 3 cycles -> outputs unchanged for 3 cycles, imem_req=0; stall drop -> fetch at pc+4.
REQ-035 redirect with redirect_pc=32'h0000_0102 during WAIT -> response discarded, valid stays 0, next imem_addr=32'h0000_0100.
REQ-036 redirect coincident with rvalid -> data discarded, next cycle REQ at redirect target.
REQ-037 fetch_pc=32'hFFFF_FFFC completes -> pcn=0, next imem_addr=0.
REQ-038 rst asserted in WAIT, stale rvalid arrives after reset -> ignored; first request at RESET_PC.
